// File: rtl/tlb_maint_ctrl_if.sv
// WB-stage request / completion handshake for the TLB maintenance sequencer.
// The master (WB stage) issues an op and holds it until req_ready; the slave
// (sequencer) answers with a one-cycle done pulse when the op has finished.
interface tlb_maint_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [31:0] inv_va;
  logic        done_valid;
  logic        done_flush;
  logic        done_ine;

  modport master (
    output req_valid, req_op, inv_op, inv_asid, inv_va,
    input  req_ready, done_valid, done_flush, done_ine
  );

  modport slave (
    input  req_valid, req_op, inv_op, inv_asid, inv_va,
    output req_ready, done_valid, done_flush, done_ine
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: executes TLBRD / TLBWR / TLBFILL / INVTLB from WB.
// Owns the single TLB read/write port, builds write entries from live CSRs,
// returns TLBRD results as CSR write data and walks every entry for INVTLB.
module tlb_maint_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              rst,
  tlb_maint_ctrl_if.slave   wb,
  input  logic [31:0]       i_csr_tlbidx,
  input  logic [31:0]       i_csr_tlbehi,
  input  logic [31:0]       i_csr_tlbelo0,
  input  logic [31:0]       i_csr_tlbelo1,
  input  logic [31:0]       i_csr_asid,
  input  logic [31:0]       i_csr_estat,
  output logic [IW-1:0]     o_r_index,
  input  logic [88:0]       i_r_entry,
  output logic              o_we,
  output logic [IW-1:0]     o_w_index,
  output logic [88:0]       o_w_entry,
  output logic              o_tlbrd_we,
  output logic [31:0]       o_tlbidx_wdata,
  output logic [31:0]       o_tlbehi_wdata,
  output logic [31:0]       o_tlbelo0_wdata,
  output logic [31:0]       o_tlbelo1_wdata,
  output logic [31:0]       o_asid_wdata
);

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam logic [1:0] OP_TLBRD   = 2'd0;
  localparam logic [1:0] OP_TLBFILL = 2'd2;
  localparam logic [1:0] OP_INVTLB  = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    r_state;
  logic [IW-1:0] r_scan_idx;
  logic [IW-1:0] r_fill_ctr;
  logic [1:0]    r_op;
  logic [4:0]    r_inv_op;
  logic [9:0]    r_inv_asid;
  logic [31:0]   r_inv_va;

  logic          w_accept;
  logic          w_inv_bad;
  logic          w_scan_last;
  logic [IW-1:0] w_r_index;
  logic          w_va_hit;
  logic          w_asid_hit;
  logic          w_match;
  tlb_entry_t    w_re;
  tlb_entry_t    w_wr_entry;
  tlb_entry_t    w_inv_entry;

  assign w_accept    = wb.req_valid && (r_state == S_IDLE);
  assign w_inv_bad   = (wb.inv_op > 5'd6);
  assign w_scan_last = (r_scan_idx == IW'(TLBNUM - 1));

  // Sequencer FSM and INVTLB walk pointer.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_scan_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (wb.req_op == OP_TLBRD)       r_state <= S_RD;
          else if (wb.req_op != OP_INVTLB) r_state <= S_WR;
          else if (w_inv_bad)              r_state <= S_DONE;
          else                             r_state <= S_SCAN;
        end
        S_RD, S_WR: r_state <= S_DONE;
        S_SCAN: begin
          if (w_scan_last) begin
            r_state    <= S_DONE;
            r_scan_idx <= '0;
          end else begin
            r_scan_idx <= r_scan_idx + IW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Free-running TLBFILL victim counter; wraps naturally because TLBNUM is 2**IW.
  always_ff @(posedge clk) begin
    if (rst) r_fill_ctr <= '0;
    else     r_fill_ctr <= r_fill_ctr + IW'(1);
  end

  // Capture the op fields on accept; WB is free to change them afterwards.
  // NOTE: these are pure datapath holding registers, only read after an accept
  // has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op       <= wb.req_op;
      r_inv_op   <= wb.inv_op;
      r_inv_asid <= wb.inv_asid;
      r_inv_va   <= wb.inv_va;
    end
  end

  assign w_re      = i_r_entry;
  assign w_r_index = (r_state == S_SCAN) ? r_scan_idx : i_csr_tlbidx[IW-1:0];
  assign o_r_index = w_r_index;

  // Build the TLBWR/TLBFILL entry from the live CSR values.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.e    = (i_csr_estat[21:16] == 6'h3F) ? 1'b1 : ~i_csr_tlbidx[31];
    w_wr_entry.vppn = i_csr_tlbehi[31:13];
    w_wr_entry.ps   = i_csr_tlbidx[29:24];
    w_wr_entry.asid = i_csr_asid[9:0];
    w_wr_entry.g    = i_csr_tlbelo0[6] & i_csr_tlbelo1[6];
    w_wr_entry.ppn0 = i_csr_tlbelo0[27:8];
    w_wr_entry.plv0 = i_csr_tlbelo0[3:2];
    w_wr_entry.mat0 = i_csr_tlbelo0[5:4];
    w_wr_entry.d0   = i_csr_tlbelo0[1];
    w_wr_entry.v0   = i_csr_tlbelo0[0];
    w_wr_entry.ppn1 = i_csr_tlbelo1[27:8];
    w_wr_entry.plv1 = i_csr_tlbelo1[3:2];
    w_wr_entry.mat1 = i_csr_tlbelo1[5:4];
    w_wr_entry.d1   = i_csr_tlbelo1[1];
    w_wr_entry.v1   = i_csr_tlbelo1[0];
  end

  // INVTLB match for the entry currently addressed by the walk.
  always_comb begin
    w_va_hit   = (w_re.ps == 6'd21) ? (w_re.vppn[18:9] == r_inv_va[31:22])
                                    : (w_re.vppn == r_inv_va[31:13]);
    w_asid_hit = (w_re.asid == r_inv_asid);
    case (r_inv_op)
      5'd0, 5'd1: w_match = 1'b1;
      5'd2:       w_match = w_re.g;
      5'd3:       w_match = ~w_re.g;
      5'd4:       w_match = ~w_re.g & w_asid_hit;
      5'd5:       w_match = ~w_re.g & w_asid_hit & w_va_hit;
      5'd6:       w_match = (w_re.g | w_asid_hit) & w_va_hit;
      default:    w_match = 1'b0;
    endcase
    w_match        = w_match & w_re.e;
    w_inv_entry    = w_re;
    w_inv_entry.e  = 1'b0;
  end

  // TLB write port. Strobes are gated by rst so a reset cycle landing mid-walk
  // cannot commit one more invalidation.
  always_comb begin
    o_we      = ~rst & ((r_state == S_WR) | ((r_state == S_SCAN) & w_match));
    o_w_index = (r_state == S_SCAN) ? r_scan_idx
              : (r_op == OP_TLBFILL) ? r_fill_ctr : i_csr_tlbidx[IW-1:0];
    o_w_entry = (r_state == S_SCAN) ? w_inv_entry : w_wr_entry;
  end

  // TLBRD result formatting; an invalid entry reports NE=1 and zeroes the rest.
  always_comb begin
    o_tlbrd_we      = ~rst & (r_state == S_RD);
    o_tlbidx_wdata  = 32'h8000_0000;
    o_tlbehi_wdata  = '0;
    o_tlbelo0_wdata = '0;
    o_tlbelo1_wdata = '0;
    o_asid_wdata    = '0;
    if (w_re.e) begin
      o_tlbidx_wdata          = '0;
      o_tlbidx_wdata[29:24]   = w_re.ps;
      o_tlbidx_wdata[IW-1:0]  = w_r_index;
      o_tlbehi_wdata          = {w_re.vppn, 13'b0};
      o_tlbelo0_wdata         = {4'b0, w_re.ppn0, 1'b0, w_re.g, w_re.mat0, w_re.plv0, w_re.d0, w_re.v0};
      o_tlbelo1_wdata         = {4'b0, w_re.ppn1, 1'b0, w_re.g, w_re.mat1, w_re.plv1, w_re.d1, w_re.v1};
      o_asid_wdata            = {22'b0, w_re.asid};
    end
  end

  // Handshake back to WB: ready only when idle, one-cycle completion pulse.
  always_comb begin
    wb.req_ready  = (r_state == S_IDLE);
    wb.done_valid = ~rst & (r_state == S_DONE);
    wb.done_flush = wb.done_valid & (r_op != OP_TLBRD);
    wb.done_ine   = wb.done_valid & (r_op == OP_INVTLB) & (r_inv_op > 5'd6);
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: directed ops push expected TLB writes,
// TLBRD results and done pulses (with their cycle) into a queue; a monitor
// thread pops and compares whenever the DUT raises one of those strobes.
module tb_tlb_maint_ctrl;
  localparam int K_WE = 0, K_RD = 1, K_DONE = 2;

  typedef struct {
    int           kind;
    int           cyc;
    logic [3:0]   idx;
    logic [88:0]  ent;
    logic [159:0] rd;
    logic         flush;
    logic         ine;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, csr_estat;
  logic [3:0]  r_index, w_index;
  logic [88:0] r_entry, w_entry;
  logic        we, tlbrd_we;
  logic [31:0] tlbidx_wdata, tlbehi_wdata, tlbelo0_wdata, tlbelo1_wdata, asid_wdata;

  logic [88:0] mem [16];
  logic        pl_en, pl_clr;
  logic [3:0]  pl_idx;
  logic [88:0] pl_data;
  int          cyc = 0;
  logic [3:0]  fill_m;
  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  tlb_maint_ctrl_if wb_if ();

  tlb_maint_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .rst(rst), .wb(wb_if.slave),
    .i_csr_tlbidx(csr_tlbidx), .i_csr_tlbehi(csr_tlbehi),
    .i_csr_tlbelo0(csr_tlbelo0), .i_csr_tlbelo1(csr_tlbelo1),
    .i_csr_asid(csr_asid), .i_csr_estat(csr_estat),
    .o_r_index(r_index), .i_r_entry(r_entry),
    .o_we(we), .o_w_index(w_index), .o_w_entry(w_entry),
    .o_tlbrd_we(tlbrd_we), .o_tlbidx_wdata(tlbidx_wdata),
    .o_tlbehi_wdata(tlbehi_wdata), .o_tlbelo0_wdata(tlbelo0_wdata),
    .o_tlbelo1_wdata(tlbelo1_wdata), .o_asid_wdata(asid_wdata)
  );

  always #5 clk = ~clk;

  // TLB array: combinational read, write on the clock edge.
  assign r_entry = mem[r_index];
  always @(posedge clk) begin
    if (pl_clr) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (we)    mem[w_index] <= w_entry;
    else if (pl_en) mem[pl_idx]  <= pl_data;
  end

  // Cycle number and the TLBFILL counter the DUT is expected to keep.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    fill_m <= rst ? 4'd0 : fill_m + 4'd1;
  end

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
      input logic [9:0] asid, input logic g, input logic [19:0] ppn0, input logic [1:0] plv0,
      input logic [1:0] mat0, input logic d0, input logic v0, input logic [19:0] ppn1,
      input logic [1:0] plv1, input logic [1:0] mat1, input logic d1, input logic v1);
    return {e, vppn, ps, asid, g, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1};
  endfunction

  task automatic push_we(input int c, input logic [3:0] idx, input logic [88:0] ent);
    exp_t e;
    e = '{kind: K_WE, cyc: c, idx: idx, ent: ent, rd: '0, flush: 1'b0, ine: 1'b0};
    q.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [159:0] rd);
    exp_t e;
    e = '{kind: K_RD, cyc: c, idx: '0, ent: '0, rd: rd, flush: 1'b0, ine: 1'b0};
    q.push_back(e);
  endtask

  task automatic push_done(input int c, input logic flush, input logic ine);
    exp_t e;
    e = '{kind: K_DONE, cyc: c, idx: '0, ent: '0, rd: '0, flush: flush, ine: ine};
    q.push_back(e);
  endtask

  task automatic handle(input int kind);
    exp_t e;
    check("event_expected", 160'(q.size() > 0), 160'(1));
    if (q.size() > 0) begin
      e = q.pop_front();
      check("event_kind", 160'(kind), 160'(e.kind));
      check("event_cycle", 160'(cyc), 160'(e.cyc));
      case (kind)
        K_WE:    begin
                   check("w_index", 160'(w_index), 160'(e.idx));
                   check("w_entry", 160'(w_entry), 160'(e.ent));
                 end
        K_RD:    check("tlbrd_wdata", {tlbidx_wdata, tlbehi_wdata, tlbelo0_wdata,
                                       tlbelo1_wdata, asid_wdata}, e.rd);
        default: check("done_flags", 160'({wb_if.done_flush, wb_if.done_ine}),
                       160'({e.flush, e.ine}));
      endcase
    end
  endtask

  task automatic run_monitor();
    forever begin
      @(negedge clk);
      if (we)               handle(K_WE);
      if (tlbrd_we)         handle(K_RD);
      if (wb_if.done_valid) handle(K_DONE);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] iop, input logic [9:0] ia,
                       input logic [31:0] iva, output int acc);
    int n;
    @(negedge clk);
    wb_if.req_op    = op;
    wb_if.inv_op    = iop;
    wb_if.inv_asid  = ia;
    wb_if.inv_va    = iva;
    wb_if.req_valid = 1'b1;
    n = 0;
    while (!wb_if.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 160'(wb_if.req_ready), 160'(1));
    @(posedge clk);
    #1;
    acc = cyc;
    wb_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 160'(q.size()), 160'(0));
    q.delete();
  endtask

  task automatic preload(input int idx, input logic [88:0] d);
    @(negedge clk);
    pl_idx  = 4'(idx);
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic clear_tlb();
    @(negedge clk);
    pl_clr = 1'b1;
    @(negedge clk);
    pl_clr = 1'b0;
  endtask

  logic [88:0] e1, e5, e6, e7, e9, e10, e11, e12, ex;
  int a;

  initial begin
    fork
      run_monitor();
    join_none
    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none

    rst = 1'b1;
    pl_en = 1'b0; pl_clr = 1'b1; pl_idx = '0; pl_data = '0;
    wb_if.req_valid = 1'b0; wb_if.req_op = '0; wb_if.inv_op = '0;
    wb_if.inv_asid = '0; wb_if.inv_va = '0;
    csr_tlbidx = '0; csr_tlbehi = '0; csr_tlbelo0 = '0; csr_tlbelo1 = '0;
    csr_asid = '0; csr_estat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pl_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 160'(wb_if.req_ready), 160'(1));
    check("reset_strobes", 160'({we, tlbrd_we, wb_if.done_valid}), 160'(0));

    // TLBWR at index 5, e from ~NE, both pages global.
    csr_tlbidx = 32'h0C00_0005; csr_tlbehi = 32'h1234_A000;
    csr_tlbelo0 = 32'h0000_1253; csr_tlbelo1 = 32'h0000_1351;
    csr_asid = 32'h0000_002A; csr_estat = 32'h0;
    e1 = mk(1'b1, 19'h091A5, 6'd12, 10'h02A, 1'b1, 20'h12, 2'd0, 2'd1, 1'b1, 1'b1,
            20'h13, 2'd0, 2'd1, 1'b0, 1'b1);
    issue(2'd1, 5'd0, 10'd0, 32'h0, a);
    push_we(a, 4'd5, e1);
    push_done(a + 1, 1'b1, 1'b0);
    drain();

    // TLBRD of the entry just written, then of an invalid entry.
    csr_tlbidx = 32'h0000_0005;
    issue(2'd0, 5'd0, 10'd0, 32'h0, a);
    push_rd(a, {32'h0C00_0005, 32'h1234_A000, 32'h0000_1253, 32'h0000_1351, 32'h0000_002A});
    push_done(a + 1, 1'b0, 1'b0);
    drain();
    csr_tlbidx = 32'h8000_0003;
    issue(2'd0, 5'd0, 10'd0, 32'h0, a);
    push_rd(a, {32'h8000_0000, 128'h0});
    push_done(a + 1, 1'b0, 1'b0);
    drain();

    // TLBFILL x3 back-to-back: ecode 0x3F overrides NE=1, index from fill counter.
    csr_tlbidx = 32'h8C00_0005; csr_estat = 32'h003F_0000;
    for (int i = 0; i < 3; i++) begin
      issue(2'd2, 5'd0, 10'd0, 32'h0, a);
      push_we(a, fill_m, e1);
      push_done(a + 1, 1'b1, 1'b0);
      @(negedge clk);
      check("fill_busy_wr", 160'(wb_if.req_ready), 160'(0));
      @(negedge clk);
      check("fill_busy_done", 160'(wb_if.req_ready), 160'(0));
    end
    drain();

    // INVTLB op5 asid 7 va 0x1234A000 over a mixed set of entries.
    csr_estat = 32'h0;
    clear_tlb();
    e5  = mk(1'b1, 19'h091A5, 6'd12, 10'd7, 1'b0, 20'h55, 2'd1, 2'd1, 1'b1, 1'b1, 20'h56, 2'd1, 2'd1, 1'b1, 1'b1);
    e6  = mk(1'b1, 19'h091A5, 6'd12, 10'd7, 1'b1, 20'h66, 2'd0, 2'd1, 1'b0, 1'b1, 20'h67, 2'd0, 2'd1, 1'b0, 1'b1);
    e7  = mk(1'b1, 19'h091A5, 6'd12, 10'd8, 1'b0, 20'h77, 2'd3, 2'd0, 1'b1, 1'b1, 20'h78, 2'd3, 2'd0, 1'b1, 1'b1);
    e9  = mk(1'b1, 19'h091A6, 6'd12, 10'd7, 1'b0, 20'h99, 2'd0, 2'd0, 1'b0, 1'b1, 20'h9A, 2'd0, 2'd0, 1'b0, 1'b1);
    e10 = mk(1'b1, 19'h09000, 6'd21, 10'd7, 1'b0, 20'hA0, 2'd0, 2'd1, 1'b1, 1'b1, 20'hA1, 2'd0, 2'd1, 1'b1, 1'b1);
    e11 = mk(1'b1, 19'h09200, 6'd21, 10'd7, 1'b0, 20'hB0, 2'd0, 2'd1, 1'b1, 1'b1, 20'hB1, 2'd0, 2'd1, 1'b1, 1'b1);
    e12 = mk(1'b0, 19'h091A5, 6'd12, 10'd7, 1'b0, 20'hC0, 2'd0, 2'd1, 1'b1, 1'b1, 20'hC1, 2'd0, 2'd1, 1'b1, 1'b1);
    preload(5, e5); preload(6, e6); preload(7, e7); preload(9, e9);
    preload(10, e10); preload(11, e11); preload(12, e12);
    issue(2'd3, 5'd5, 10'd7, 32'h1234_A000, a);
    ex = e5;  ex[88] = 1'b0; push_we(a + 5, 4'd5, ex);
    ex = e10; ex[88] = 1'b0; push_we(a + 10, 4'd10, ex);
    push_done(a + 16, 1'b1, 1'b0);
    drain();

    // INVTLB op6: global-or-asid with VA; only entry 6 is still valid and hits.
    issue(2'd3, 5'd6, 10'd7, 32'h1234_A000, a);
    ex = e6; ex[88] = 1'b0; push_we(a + 6, 4'd6, ex);
    push_done(a + 16, 1'b1, 1'b0);
    drain();

    // INVTLB with an undefined op: no walk, immediate done with ine.
    issue(2'd3, 5'd9, 10'd0, 32'h0, a);
    push_done(a, 1'b1, 1'b1);
    drain();

    // INVTLB op0 aborted by reset while the walk sits on entry 4.
    for (int i = 0; i < 16; i++)
      preload(i, mk(1'b1, 19'(i), 6'd12, 10'(i), 1'b0, 20'(i), 2'd0, 2'd0, 1'b0, 1'b1,
                    20'(i), 2'd0, 2'd0, 1'b0, 1'b1));
    issue(2'd3, 5'd0, 10'd0, 32'h0, a);
    for (int i = 0; i < 4; i++)
      push_we(a + i, 4'(i), mk(1'b0, 19'(i), 6'd12, 10'(i), 1'b0, 20'(i), 2'd0, 2'd0, 1'b0, 1'b1,
                               20'(i), 2'd0, 2'd0, 1'b0, 1'b1));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 160'(wb_if.req_ready), 160'(1));
    for (int i = 0; i < 16; i++)
      check("abort_entry", 160'(mem[i]),
            160'(mk((i >= 4), 19'(i), 6'd12, 10'(i), 1'b0, 20'(i), 2'd0, 2'd0, 1'b0, 1'b1,
                    20'(i), 2'd0, 2'd0, 1'b0, 1'b1)));
    repeat (20) @(negedge clk);
    check("abort_no_events_left", 160'(q.size()), 160'(0));

    // TLBFILL after reset: the fill counter restarted with the reset.
    csr_tlbidx = 32'h0C00_0000;
    issue(2'd2, 5'd0, 10'd0, 32'h0, a);
    push_we(a, fill_m, e1);
    push_done(a + 1, 1'b1, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
